// File: rtl/tsw_pkg.sv
// Shared types and packet field helpers for the buffered BFT T-switch.
package tsw_pkg;

    typedef enum logic [1:0] {
        PORT_L = 2'd0,
        PORT_R = 2'd1,
        PORT_U = 2'd2
    } port_e;

    function automatic int valid_pos(input int a, input int p);
        return a + p;
    endfunction

    function automatic int addr_hi(input int a, input int p);
        return a + p - 1;
    endfunction

    function automatic int addr_lo(input int p);
        return p;
    endfunction

    function automatic int payload_hi(input int p);
        return p - 1;
    endfunction

    // The two sources that may feed a given output, in reset-priority order.
    function automatic port_e cand0(input port_e d);
        return (d == PORT_L) ? PORT_R : PORT_L;
    endfunction

    function automatic port_e cand1(input port_e d);
        return (d == PORT_U) ? PORT_R : PORT_U;
    endfunction

endpackage

// File: rtl/tsw_in_fifo.sv
// Per-port input FIFO; wr_rdy is a registered !full, held low during reset.
module tsw_in_fifo #(
    parameter int depth = 2,
    parameter int width = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] wr_data,
    input  logic             wr_vld,
    output logic             wr_rdy,
    output logic [width-1:0] rd_data,
    output logic             rd_vld,
    input  logic             rd_pop
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [width-1:0] mem [depth];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_nxt, rd_nxt;
    logic        empty;
    logic        push, pop;

    always_comb begin
        push   = wr_vld && wr_rdy;
        pop    = rd_pop && !empty;
        wr_nxt = push ? wr_ptr + ONE : wr_ptr;
        rd_nxt = pop ? rd_ptr + ONE : rd_ptr;
    end

    // Full when pointers differ only in the wrap bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            wr_rdy <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            wr_rdy <= !((wr_nxt[AW] != rd_nxt[AW]) &&
                        (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign rd_vld  = !empty;

endmodule

// File: rtl/t_switch_rr.sv
// Buffered BFT T-switch: input FIFOs, per-output 2:1 round-robin, route drop.
// Define TSW_PERF_CNT_EN to add per-output transfer counters.
import tsw_pkg::*;

module t_switch_rr #(
    parameter int num_leaves = 8,
    parameter int payload_sz = 8,
    parameter int this_level = 0,
    parameter int this_addr  = 0,
    parameter int fifo_depth = 2,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [p_sz-1:0] l_bus_i,
    input  logic [p_sz-1:0] r_bus_i,
    input  logic [p_sz-1:0] u_bus_i,
    output logic            l_rdy_o,
    output logic            r_rdy_o,
    output logic            u_rdy_o,
    output logic [p_sz-1:0] l_bus_o,
    output logic [p_sz-1:0] r_bus_o,
    output logic [p_sz-1:0] u_bus_o,
    input  logic            l_rdy_i,
    input  logic            r_rdy_i,
    input  logic            u_rdy_i,
`ifdef TSW_PERF_CNT_EN
    output logic [31:0]     l_cnt_o,
    output logic [31:0]     r_cnt_o,
    output logic [31:0]     u_cnt_o,
`endif
    output logic            err_o
);

    localparam int A       = $clog2(num_leaves);
    localparam int VB      = valid_pos(A, payload_sz);
    localparam int ADDR_HI = addr_hi(A, payload_sz);
    localparam int ADDR_LO = addr_lo(payload_sz);
    localparam int SHIFT   = A - this_level;
    localparam int DIR     = (this_level < A) ? A - 1 - this_level : 0;

    logic [p_sz-1:0] bus_in [3];
    logic [p_sz-1:0] head   [3];
    logic [p_sz-1:0] out_q  [3];
    port_e           dest   [3];
    logic [2:0]      head_vld, rdy_out, rdy_in;
    logic [2:0]      pop, drop, gnt0, gnt1, ptr;
    logic            req0, req1, free;

    function automatic port_e route(input logic [A-1:0] a);
        logic match;
        match = (this_level == 0) || ((a >> SHIFT) == A'(this_addr));
        if (!match) return PORT_U;
        return a[DIR] ? PORT_R : PORT_L;
    endfunction

    assign bus_in[PORT_L] = l_bus_i;
    assign bus_in[PORT_R] = r_bus_i;
    assign bus_in[PORT_U] = u_bus_i;
    assign rdy_in = {u_rdy_i, r_rdy_i, l_rdy_i};

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        tsw_in_fifo #(
            .depth(fifo_depth),
            .width(p_sz)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .wr_data(bus_in[i]),
            .wr_vld (bus_in[i][VB]),
            .wr_rdy (rdy_out[i]),
            .rd_data(head[i]),
            .rd_vld (head_vld[i]),
            .rd_pop (pop[i])
        );
    end

    always_comb begin
        pop  = '0;
        drop = '0;
        gnt0 = '0;
        gnt1 = '0;
        req0 = 1'b0;
        req1 = 1'b0;
        free = 1'b0;
        for (int s = 0; s < 3; s++) begin
            dest[s] = route(head[s][ADDR_HI:ADDR_LO]);
            drop[s] = head_vld[s] && (dest[s] == port_e'(s));
        end
        // A slot being drained this cycle can be refilled in the same cycle.
        for (int d = 0; d < 3; d++) begin
            req0 = head_vld[cand0(port_e'(d))] &&
                   (dest[cand0(port_e'(d))] == port_e'(d));
            req1 = head_vld[cand1(port_e'(d))] &&
                   (dest[cand1(port_e'(d))] == port_e'(d));
            free = !out_q[d][VB] || rdy_in[d];
            gnt0[d] = free && req0 && (!ptr[d] || !req1);
            gnt1[d] = free && req1 && (ptr[d] || !req0);
            if (gnt0[d]) pop[cand0(port_e'(d))] = 1'b1;
            if (gnt1[d]) pop[cand1(port_e'(d))] = 1'b1;
        end
        pop = pop | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) out_q[d] <= '0;
            ptr   <= '0;
            err_o <= 1'b0;
        end else begin
            err_o <= |drop;
            for (int d = 0; d < 3; d++) begin
                unique case (1'b1)
                    gnt0[d]: begin
                        out_q[d] <= head[cand0(port_e'(d))];
                        ptr[d]   <= 1'b1;
                    end
                    gnt1[d]: begin
                        out_q[d] <= head[cand1(port_e'(d))];
                        ptr[d]   <= 1'b0;
                    end
                    default: begin
                        if (out_q[d][VB] && rdy_in[d]) out_q[d] <= '0;
                    end
                endcase
            end
        end
    end

    assign l_bus_o = out_q[PORT_L];
    assign r_bus_o = out_q[PORT_R];
    assign u_bus_o = out_q[PORT_U];
    assign l_rdy_o = rdy_out[PORT_L];
    assign r_rdy_o = rdy_out[PORT_R];
    assign u_rdy_o = rdy_out[PORT_U];

`ifdef TSW_PERF_CNT_EN
    logic [31:0] cnt_q [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 3; d++) cnt_q[d] <= '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (out_q[d][VB] && rdy_in[d]) cnt_q[d] <= cnt_q[d] + 32'd1;
            end
        end
    end

    assign l_cnt_o = cnt_q[PORT_L];
    assign r_cnt_o = cnt_q[PORT_R];
    assign u_cnt_o = cnt_q[PORT_U];
`endif

endmodule
